// File: rtl/octopus_deparser.sv
`default_nettype none
// ============================================================================
//  Module      : octopus_deparser
//  Description : Transmit-side frame builder. Takes one five-tuple plus up to
//                64 payload bytes per request and emits an Ethernet/IPv4 frame
//                carrying a UDP or TCP header on a 512-bit AXI-Stream master.
//  Ports       : clk, rst (sync, active-low)
//                in_five_tuple/in_payload/in_payload_len/in_valid -> in_ready
//                m_axis_tdata/tkeep/tuser/tvalid/tlast <- m_axis_tready
//  Revision    : 1.0  initial release
// ============================================================================
module octopus_deparser #(
  parameter int          C_M_AXIS_TDATA_WIDTH = 512,
  parameter int          C_M_AXIS_TKEEP_WIDTH = 64,
  parameter int          C_M_AXIS_TUSER_WIDTH = 256,
  parameter logic [47:0] SRC_MAC              = 48'h0A0000000001,
  parameter logic [47:0] DST_MAC              = 48'h0A0000000002,
  parameter logic [7:0]  IP_TTL               = 8'd64,
  parameter logic [15:0] TCP_WINDOW           = 16'hFFFF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [175:0]                    in_five_tuple,
  input  logic [511:0]                    in_payload,
  input  logic [6:0]                      in_payload_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_M_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  localparam logic [7:0] C_MIN_FRAME = 8'd60;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CSUM  = 2'd1,
    S_BEAT0 = 2'd2,
    S_BEAT1 = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [103:0]                      tuple_q, tuple_d;
  logic [511:0]                      payload_q, payload_d;
  logic [6:0]                        len_q, len_d;
  logic [15:0]                       csum_q, csum_d;
  logic [15:0]                       ip_id_q, ip_id_d;
  logic                              in_ready_q, in_ready_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic [C_M_AXIS_TKEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;

  logic          is_tcp;
  logic [7:0]    ip_proto, hdr_len, total_len, frame_len, beat1_len;
  logic [15:0]   ip_len, l4_len, csum_calc, csum_use;
  logic [19:0]   csum_sum;
  logic [16:0]   csum_fold1, csum_fold2;
  logic [7:0]    hb [54];
  logic [511:0]  pay_wire;
  logic [1023:0] frame;
  logic          unused_bits;

  assign unused_bits = ^{in_five_tuple[175:104], csum_fold2[16]};

  // Low n bits set; n >= 64 yields all ones because the shift empties the word.
  function automatic logic [63:0] keep_mask(input logic [7:0] n);
    keep_mask = ~({64{1'b1}} << n);
  endfunction

  // Whole frame image (wire byte k at [8k+7:8k]) built from the latched request.
  always_comb begin
    is_tcp    = (tuple_q[7:0] == 8'd6);
    ip_proto  = is_tcp ? 8'd6 : 8'd17;
    hdr_len   = is_tcp ? 8'd54 : 8'd42;
    total_len = hdr_len + {1'b0, len_q};
    frame_len = (total_len < C_MIN_FRAME) ? C_MIN_FRAME : total_len;
    beat1_len = frame_len - 8'd64;
    ip_len    = {8'h00, total_len} - 16'd14;
    l4_len    = 16'd8 + {9'h000, len_q};

    csum_sum   = 20'h04500 + {4'h0, ip_len} + {4'h0, ip_id_q} + 20'h04000
               + {4'h0, IP_TTL, ip_proto}
               + {4'h0, tuple_q[103:88]} + {4'h0, tuple_q[87:72]}
               + {4'h0, tuple_q[71:56]}  + {4'h0, tuple_q[55:40]};
    csum_fold1 = {1'b0, csum_sum[15:0]} + {13'h0000, csum_sum[19:16]};
    csum_fold2 = {1'b0, csum_fold1[15:0]} + {16'h0000, csum_fold1[16]};
    csum_calc  = ~csum_fold2[15:0];
    // Beat 0 is registered on the same edge that captures the checksum.
    csum_use   = (state_q == S_CSUM) ? csum_calc : csum_q;

    for (int k = 0; k < 54; k++) hb[k] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      hb[k]     = DST_MAC[47-8*k -: 8];
      hb[6+k]   = SRC_MAC[47-8*k -: 8];
    end
    hb[12] = 8'h08;          hb[13] = 8'h00;
    hb[14] = 8'h45;          hb[15] = 8'h00;
    hb[16] = ip_len[15:8];   hb[17] = ip_len[7:0];
    hb[18] = ip_id_q[15:8];  hb[19] = ip_id_q[7:0];
    hb[20] = 8'h40;          hb[21] = 8'h00;
    hb[22] = IP_TTL;         hb[23] = ip_proto;
    hb[24] = csum_use[15:8]; hb[25] = csum_use[7:0];
    // sip, dip, sport, dport sit contiguously in the tuple, MSB first.
    for (int k = 0; k < 12; k++) hb[26+k] = tuple_q[103-8*k -: 8];
    if (is_tcp) begin
      hb[46] = 8'h50;             hb[47] = 8'h18;
      hb[48] = TCP_WINDOW[15:8];  hb[49] = TCP_WINDOW[7:0];
    end else begin
      hb[38] = l4_len[15:8];      hb[39] = l4_len[7:0];
    end

    // Payload bytes past len are forced to zero so padding stays clean.
    for (int i = 0; i < 64; i++)
      pay_wire[8*i +: 8] = (i < int'(len_q)) ? payload_q[511-8*i -: 8] : 8'h00;

    frame = '0;
    for (int k = 0; k < 54; k++) frame[8*k +: 8] = hb[k];
    if (is_tcp) frame = frame | ({512'h0, pay_wire} << 432);
    else        frame = frame | ({512'h0, pay_wire} << 336);
  end

  always_comb begin
    state_d    = state_q;
    tuple_d    = tuple_q;
    payload_d  = payload_q;
    len_d      = len_q;
    csum_d     = csum_q;
    ip_id_d    = ip_id_q;
    in_ready_d = in_ready_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          tuple_d    = in_five_tuple[103:0];
          payload_d  = in_payload;
          len_d      = (in_payload_len > 7'd64) ? 7'd64 : in_payload_len;
          in_ready_d = 1'b0;
          state_d    = S_CSUM;
        end
      end
      S_CSUM: begin
        csum_d   = csum_calc;
        state_d  = S_BEAT0;
        tvalid_d = 1'b1;
        tlast_d  = (frame_len <= 8'd64);
        tkeep_d  = keep_mask(frame_len);
        tdata_d  = frame[511:0];
        tuser_d  = {{(C_M_AXIS_TUSER_WIDTH-8){1'b0}}, frame_len};
      end
      S_BEAT0: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            tkeep_d    = '0;
            tdata_d    = '0;
            tuser_d    = '0;
            ip_id_d    = ip_id_q + 16'd1;
          end else begin
            state_d = S_BEAT1;
            tdata_d = frame[1023:512];
            tkeep_d = keep_mask(beat1_len);
            tlast_d = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (m_axis_tready) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          tvalid_d   = 1'b0;
          tlast_d    = 1'b0;
          tkeep_d    = '0;
          tdata_d    = '0;
          tuser_d    = '0;
          ip_id_d    = ip_id_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tuple_q    <= '0;
      payload_q  <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      ip_id_q    <= '0;
      in_ready_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= '0;
      tdata_q    <= '0;
      tuser_q    <= '0;
    end else begin
      state_q    <= state_d;
      tuple_q    <= tuple_d;
      payload_q  <= payload_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      ip_id_q    <= ip_id_d;
      in_ready_q <= in_ready_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_octopus_deparser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octopus_deparser
//  Description : Self-checking bench for octopus_deparser. A byte-queue model
//                of the frame layout supplies every expected beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_octopus_deparser;

  logic         clk = 1'b0;
  logic         rst;
  logic [175:0] in_five_tuple;
  logic [511:0] in_payload;
  logic [6:0]   in_payload_len;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [255:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;

  always #5 clk = ~clk;

  octopus_deparser dut (
    .clk            (clk),
    .rst            (rst),
    .in_five_tuple  (in_five_tuple),
    .in_payload     (in_payload),
    .in_payload_len (in_payload_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_id;
  logic [7:0]  exp_b [128];
  int          exp_flen;
  logic [7:0]  rx_b  [128];

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: append fields in wire order, pad, then patch the checksum.
  task automatic build_expected(input logic [103:0] t, input logic [511:0] p,
                                input int len_in, input logic [15:0] id);
    logic [7:0]  q[$];
    logic [47:0] dst = 48'h0A0000000002;
    logic [47:0] src = 48'h0A0000000001;
    int          len = (len_in > 64) ? 64 : len_in;
    bit          tcp = (t[7:0] == 8'd6);
    int          tot;
    int unsigned s;
    q = {};
    for (int k = 0; k < 6; k++) q.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) q.push_back(src[47-8*k -: 8]);
    tot = (tcp ? 54 : 42) + len;
    q.push_back(8'h08); q.push_back(8'h00);
    q.push_back(8'h45); q.push_back(8'h00);
    q.push_back(8'((tot - 14) >> 8)); q.push_back(8'(tot - 14));
    q.push_back(id[15:8]); q.push_back(id[7:0]);
    q.push_back(8'h40); q.push_back(8'h00); q.push_back(8'd64);
    q.push_back(tcp ? 8'd6 : 8'd17);
    q.push_back(8'h00); q.push_back(8'h00);
    for (int k = 0; k < 12; k++) q.push_back(t[103-8*k -: 8]);
    if (!tcp) begin
      q.push_back(8'((8 + len) >> 8)); q.push_back(8'(8 + len));
      q.push_back(8'h00); q.push_back(8'h00);
    end else begin
      for (int k = 0; k < 8; k++) q.push_back(8'h00);
      q.push_back(8'h50); q.push_back(8'h18); q.push_back(8'hFF); q.push_back(8'hFF);
      for (int k = 0; k < 4; k++) q.push_back(8'h00);
    end
    for (int i = 0; i < len; i++) q.push_back(p[511-8*i -: 8]);
    while (q.size() < 60) q.push_back(8'h00);
    s = 0;
    for (int w = 0; w < 10; w++) s += 32'({q[14+2*w], q[15+2*w]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    s = ~s & 32'hFFFF;
    q[24] = 8'(s >> 8);
    q[25] = 8'(s);
    exp_flen = q.size();
    for (int k = 0; k < 128; k++) exp_b[k] = (k < exp_flen) ? q[k] : 8'h00;
  endtask

  function automatic logic [511:0] exp_data(input int b);
    logic [511:0] d = '0;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = exp_b[64*b+k];
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int b);
    logic [63:0] m = '0;
    for (int k = 0; k < 64; k++) m[k] = ((64*b + k) < exp_flen);
    return m;
  endfunction

  function automatic logic [15:0] rx16(input int a);
    return {rx_b[a], rx_b[a+1]};
  endfunction

  function automatic logic [511:0] rand_payload();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [175:0] rand_tuple();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom();
    case ($urandom_range(0, 3))
      0, 1:    r[7:0] = 8'd6;
      2:       r[7:0] = 8'd17;
      default: ;
    endcase
    return r[175:0];
  endfunction

  task automatic send_req(input logic [175:0] t, input logic [511:0] p, input logic [6:0] l);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 512'(in_ready), 512'(1));
    in_five_tuple  = t;
    in_payload     = p;
    in_payload_len = l;
    in_valid       = 1'b1;
    @(negedge clk);
    in_valid       = 1'b0;
  endtask

  // Observe at negedges; every valid cycle (stalled or not) must show the expected beat.
  task automatic collect(input bit stall);
    int beat  = 0;
    int guard = 0;
    bit done  = 0;
    bit rdy;
    int nb    = (exp_flen > 64) ? 2 : 1;
    while (!done && guard < 300) begin
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_axis_tready = rdy;
      if (m_axis_tvalid) begin
        if (beat < nb) begin
          check_eq("tdata", m_axis_tdata, exp_data(beat));
          check_eq("tkeep", 512'(m_axis_tkeep), 512'(exp_keep(beat)));
          check_eq("tlast", 512'(m_axis_tlast), 512'(beat == nb - 1));
          check_eq("tuser", 512'(m_axis_tuser), 512'(exp_flen));
        end else begin
          check_eq("extra_beat", 512'(beat), 512'(nb));
        end
        if (rdy) begin
          if (beat < 2)
            for (int k = 0; k < 64; k++) rx_b[64*beat+k] = m_axis_tdata[8*k +: 8];
          beat++;
          if (m_axis_tlast) done = 1;
        end
      end
      @(negedge clk);
      guard++;
    end
    m_axis_tready = 1'b0;
    check_eq("beats", 512'(beat), 512'(nb));
  endtask

  task automatic run_frame(input logic [175:0] t, input logic [511:0] p,
                           input logic [6:0] l, input bit stall);
    for (int k = 0; k < 128; k++) rx_b[k] = 8'h00;
    build_expected(t[103:0], p, int'(l), model_id);
    send_req(t, p, l);
    collect(stall);
    model_id = model_id + 16'd1;
  endtask

  // Receiver-side view: header checksum verifies and the tuple parses back.
  task automatic verify_rx_hdr(input logic [103:0] t);
    int unsigned  s = 0;
    logic [95:0]  tup;
    for (int w = 0; w < 10; w++) s += 32'(rx16(14 + 2*w));
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    check_eq("csum_verify", 512'(s), 512'(16'hFFFF));
    for (int k = 0; k < 12; k++) tup[95-8*k -: 8] = rx_b[26+k];
    check_eq("loopback_tuple", 512'(tup), 512'(t[103:8]));
  endtask

  initial begin
    logic [175:0] t;
    logic [511:0] p;
    logic [143:0] z;
    int           g;

    rst            = 1'b0;
    in_valid       = 1'b0;
    in_five_tuple  = '0;
    in_payload     = '0;
    in_payload_len = '0;
    m_axis_tready  = 1'b0;
    model_id       = 16'h0000;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 512'(in_ready), 512'(0));
    check_eq("rst_tvalid",   512'(m_axis_tvalid), 512'(0));
    check_eq("rst_tlast",    512'(m_axis_tlast), 512'(0));
    check_eq("rst_tkeep",    512'(m_axis_tkeep), 512'(0));
    check_eq("rst_tdata",    m_axis_tdata, 512'(0));
    check_eq("rst_tuser",    512'(m_axis_tuser), 512'(0));
    rst = 1'b1;

    // UDP, 22 bytes: exactly one full beat
    t = {72'h0, 32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 8'd17};
    p = rand_payload();
    run_frame(t, p, 7'd22, 1'b0);
    check_eq("udp22_l4len", 512'(rx16(38)), 512'(16'h001E));
    check_eq("udp22_iplen", 512'(rx16(16)), 512'(16'h0032));
    verify_rx_hdr(t[103:0]);

    // TCP, 64 bytes: two beats
    t[7:0] = 8'd6;
    p = rand_payload();
    run_frame(t, p, 7'd64, 1'b0);
    check_eq("tcp64_iplen", 512'(rx16(16)), 512'(16'h0068));
    check_eq("tcp64_byte117", 512'(rx_b[117]), 512'(p[7:0]));
    verify_rx_hdr(t[103:0]);

    // UDP, empty payload: padded to 60 bytes
    t[7:0] = 8'd17;
    p = rand_payload();
    run_frame(t, p, 7'd0, 1'b0);
    check_eq("udp0_iplen", 512'(rx16(16)), 512'(16'h001C));
    for (int k = 0; k < 18; k++) z[8*k +: 8] = rx_b[42+k];
    check_eq("udp0_pad", 512'(z), 512'(0));

    // Oversized length clamps to 64, with stalls
    run_frame(rand_tuple(), rand_payload(), 7'd100, 1'b1);

    // ip_id wrap: hold the counter at 0xFFFF for one frame
    t = rand_tuple();
    p = rand_payload();
    @(negedge clk);
    force dut.ip_id_q = 16'hFFFF;
    model_id = 16'hFFFF;
    build_expected(t[103:0], p, 40, model_id);
    send_req(t, p, 7'd40);
    g = 0;
    while (!m_axis_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    release dut.ip_id_q;
    collect(1'b0);
    model_id = model_id + 16'd1;
    check_eq("ipid_ffff", 512'(rx16(18)), 512'(16'hFFFF));
    run_frame(rand_tuple(), rand_payload(), 7'd10, 1'b0);
    check_eq("ipid_wrap", 512'(rx16(18)), 512'(16'h0000));
    run_frame(rand_tuple(), rand_payload(), 7'd10, 1'b0);

    // Reset while the second beat is pending
    t = rand_tuple();
    t[7:0] = 8'd6;
    p = rand_payload();
    build_expected(t[103:0], p, 64, model_id);
    send_req(t, p, 7'd64);
    g = 0;
    while (!m_axis_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check_eq("b1_tvalid", 512'(m_axis_tvalid), 512'(1));
    check_eq("b1_tlast",  512'(m_axis_tlast), 512'(1));
    check_eq("b1_tdata",  m_axis_tdata, exp_data(1));
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_b1_tvalid", 512'(m_axis_tvalid), 512'(0));
    check_eq("rst_b1_tlast",  512'(m_axis_tlast), 512'(0));
    check_eq("rst_b1_tkeep",  512'(m_axis_tkeep), 512'(0));
    rst = 1'b1;
    model_id = 16'h0000;
    t = rand_tuple();
    run_frame(t, rand_payload(), 7'($urandom_range(0, 64)), 1'b1);
    check_eq("rst_ipid", 512'(rx16(18)), 512'(16'h0000));
    verify_rx_hdr(t[103:0]);

    // Random frames with random back-pressure
    for (int n = 0; n < 3000; n++) begin
      t = rand_tuple();
      run_frame(t, rand_payload(), 7'($urandom_range(0, 80)), 1'b1);
      verify_rx_hdr(t[103:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
